// File: rtl/stall_flush_controller.sv
// Pipeline hazard controller: load-use bubbles, branch flushes and memory-wait freezes,
// with saturating performance counters for stall, flush and wait cycles.
module stall_flush_controller #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memread_id,
  input  logic [4:0]       rd_id,
  input  logic [4:0]       rs1_if,
  input  logic [4:0]       rs2_if,
  input  logic             jump_ex,
  input  logic             mem_busy,
  input  logic             clear_counters,
  output logic             enable_pc,
  output logic             enable_if,
  output logic             enable_control,
  output logic             enable_pipe,
  output logic             flush_if,
  output logic             flush_id,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LSTALL = 2'd1,
    MWAIT  = 2'd2
  } state_t;

  localparam logic [1:0]       STALL_INIT = 2'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_t     state_reg, state_next;
  logic [1:0] remaining_reg, remaining_next;
  logic       flush_pending_reg, flush_pending_next;
  logic       hazard;

  assign hazard = memread_id && (rd_id != 5'd0) &&
                  ((rd_id == rs1_if) || (rd_id == rs2_if));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg         <= RUN;
      remaining_reg     <= 2'd0;
      flush_pending_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      remaining_reg     <= remaining_next;
      flush_pending_reg <= flush_pending_next;
    end
  end

  always_comb begin
    state_next         = RUN;
    remaining_next     = 2'd0;
    flush_pending_next = flush_pending_reg;
    enable_pc          = 1'b1;
    enable_if          = 1'b1;
    enable_control     = 1'b1;
    enable_pipe        = 1'b1;
    flush_if           = 1'b0;
    flush_id           = 1'b0;

    if (mem_busy) begin
      enable_pc   = 1'b0;
      enable_if   = 1'b0;
      enable_pipe = 1'b0;
      state_next  = MWAIT;
      if (jump_ex) flush_pending_next = 1'b1;
    end else if (state_reg == MWAIT) begin
      // Exit cycle runs with defaults; a jump resolving here is deferred, not lost.
      if (jump_ex) flush_pending_next = 1'b1;
    end else if (jump_ex || flush_pending_reg) begin
      flush_if           = 1'b1;
      flush_id           = 1'b1;
      flush_pending_next = 1'b0;
    end else if (state_reg == LSTALL) begin
      enable_pc      = 1'b0;
      enable_if      = 1'b0;
      enable_control = 1'b0;
      if (remaining_reg > 2'd1) begin
        state_next     = LSTALL;
        remaining_next = remaining_reg - 2'd1;
      end
    end else if (hazard) begin
      enable_pc      = 1'b0;
      enable_if      = 1'b0;
      enable_control = 1'b0;
      if (LOAD_STALL_CYCLES > 1) begin
        state_next     = LSTALL;
        remaining_next = STALL_INIT;
      end
    end

    // Reset squashes everything in flight and holds the pipeline still.
    if (reset) begin
      enable_pc      = 1'b0;
      enable_if      = 1'b0;
      enable_control = 1'b0;
      enable_pipe    = 1'b0;
      flush_if       = 1'b1;
      flush_id       = 1'b1;
    end
  end

  assign state_o = state_reg;

  logic [2:0]            cnt_inc;
  logic [2:0][CNT_W-1:0] cnt_val;

  assign cnt_inc = {mem_busy, flush_if, ~enable_control};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_reg <= '0;
        end else if (clear_counters) begin
          cnt_reg <= '0;
        end else if (cnt_inc[gi] && (cnt_reg != CNT_MAX)) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign cnt_val[gi] = cnt_reg;
    end
  endgenerate

  assign stall_cnt = cnt_val[0];
  assign flush_cnt = cnt_val[1];
  assign wait_cnt  = cnt_val[2];

endmodule

// File: tb/tb_stall_flush_controller.sv
// Randomised and directed bench for stall_flush_controller against a cycle-level
// behavioural model (owed bubbles, frozen flag, pending flush, saturating tallies).
module tb_stall_flush_controller;

  localparam int LSC = 2;
  localparam int CW  = 4;
  localparam int CAP = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset, memread_id, jump_ex, mem_busy, clear_counters;
  logic [4:0]    rd_id, rs1_if, rs2_if;
  logic          enable_pc, enable_if, enable_control, enable_pipe, flush_if, flush_id;
  logic [1:0]    state_o;
  logic [CW-1:0] stall_cnt, flush_cnt, wait_cnt;

  stall_flush_controller #(.LOAD_STALL_CYCLES(LSC), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .memread_id(memread_id), .rd_id(rd_id),
    .rs1_if(rs1_if), .rs2_if(rs2_if), .jump_ex(jump_ex), .mem_busy(mem_busy),
    .clear_counters(clear_counters), .enable_pc(enable_pc), .enable_if(enable_if),
    .enable_control(enable_control), .enable_pipe(enable_pipe), .flush_if(flush_if),
    .flush_id(flush_id), .state_o(state_o), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: bubbles still owed, frozen on memory, deferred flush, counter values.
  int m_bubbles = 0;
  bit m_frozen  = 0;
  bit m_pend    = 0;
  int m_sc = 0, m_fc = 0, m_wc = 0;
  int kind;  // 0 reset, 1 freeze, 2 wait-exit, 3 flush, 4 bubble, 5 idle

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_in(input bit mr, input int rd, input int r1, input int r2,
                        input bit j, input bit mb, input bit cc, input bit rst);
    memread_id = mr; rd_id = 5'(rd); rs1_if = 5'(r1); rs2_if = 5'(r2);
    jump_ex = j; mem_busy = mb; clear_counters = cc; reset = rst;
  endtask

  function automatic bit spec_hazard();
    return memread_id && (rd_id != 0) && (rd_id == rs1_if || rd_id == rs2_if);
  endfunction

  // Sample at the falling edge and compare every output with the model.
  task automatic cycle();
    int e_pc, e_ctrl, e_pipe, e_fl, e_st;
    @(negedge clk);
    if (reset) begin
      m_bubbles = 0; m_frozen = 0; m_pend = 0; m_sc = 0; m_fc = 0; m_wc = 0;
      kind = 0;
    end else if (mem_busy)                    kind = 1;
    else if (m_frozen)                        kind = 2;
    else if (jump_ex || m_pend)               kind = 3;
    else if (m_bubbles > 0 || spec_hazard())  kind = 4;
    else                                      kind = 5;
    e_pc   = (kind == 0 || kind == 1 || kind == 4) ? 0 : 1;
    e_ctrl = (kind == 0 || kind == 4) ? 0 : 1;
    e_pipe = (kind == 0 || kind == 1) ? 0 : 1;
    e_fl   = (kind == 0 || kind == 3) ? 1 : 0;
    e_st   = m_frozen ? 2 : (m_bubbles > 0 ? 1 : 0);
    chk("enable_pc", enable_pc, e_pc);
    chk("enable_if", enable_if, e_pc);
    chk("enable_control", enable_control, e_ctrl);
    chk("enable_pipe", enable_pipe, e_pipe);
    chk("flush_if", flush_if, e_fl);
    chk("flush_id", flush_id, e_fl);
    chk("state_o", state_o, e_st);
    chk("stall_cnt", stall_cnt, m_sc);
    chk("flush_cnt", flush_cnt, m_fc);
    chk("wait_cnt", wait_cnt, m_wc);
    $display("cyc %0d rst=%0b mr=%0b rd=%0d rs=%0d/%0d j=%0b mb=%0b clr=%0b -> st=%0d pc=%0b ctl=%0b pipe=%0b fl=%0b cnt=%0d/%0d/%0d",
             cyc, reset, memread_id, rd_id, rs1_if, rs2_if, jump_ex, mem_busy, clear_counters,
             state_o, enable_pc, enable_control, enable_pipe, flush_if, stall_cnt, flush_cnt, wait_cnt);
  endtask

  // Advance the model across the rising edge, then release inputs for the next cycle.
  task automatic adv();
    @(posedge clk);
    case (kind)
      1: begin m_frozen = 1; m_bubbles = 0; m_pend = m_pend | jump_ex; m_wc++; end
      2: begin m_frozen = 0; m_pend = m_pend | jump_ex; end
      3: begin m_pend = 0; m_bubbles = 0; m_fc++; end
      4: begin m_sc++; m_bubbles = (m_bubbles > 0) ? m_bubbles - 1 : LSC - 1; end
      default: ;
    endcase
    if (m_sc > CAP) m_sc = CAP;
    if (m_fc > CAP) m_fc = CAP;
    if (m_wc > CAP) m_wc = CAP;
    if (kind != 0 && clear_counters) begin m_sc = 0; m_fc = 0; m_wc = 0; end
    cyc++;
    #1;
  endtask

  initial begin
    int busy_left = 0;
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    cycle(); chk("lit_reset_flush", flush_if, 1); chk("lit_reset_pc", enable_pc, 0); adv();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(); adv();

    // Load-use with two bubbles: states 0,1,0.
    set_in(1, 5, 0, 5, 0, 0, 0, 0);
    cycle(); chk("lit_lu_st0", state_o, 0); chk("lit_lu_pc0", enable_pc, 0); adv();
    cycle(); chk("lit_lu_st1", state_o, 1); chk("lit_lu_ctl1", enable_control, 0); adv();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(); chk("lit_lu_st2", state_o, 0); chk("lit_lu_pc2", enable_pc, 1);
    chk("lit_lu_cnt", stall_cnt, 2); adv();

    // Load to x0 is never a hazard.
    set_in(1, 0, 0, 3, 0, 0, 0, 0);
    cycle(); chk("lit_x0_pc", enable_pc, 1); chk("lit_x0_ctl", enable_control, 1); adv();

    // Jump beats a simultaneous hazard.
    set_in(1, 5, 0, 5, 1, 0, 0, 0);
    cycle(); chk("lit_jh_fif", flush_if, 1); chk("lit_jh_fid", flush_id, 1);
    chk("lit_jh_pc", enable_pc, 1); adv();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(); chk("lit_jh_sc", stall_cnt, 2); chk("lit_jh_fc", flush_cnt, 1); adv();

    // Three-cycle freeze with a captured jump, then exit, then deferred flush.
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    cycle(); adv();
    set_in(0, 0, 0, 0, 0, 1, 0, 0);
    cycle(); chk("lit_fz_pc", enable_pc, 0); adv();
    set_in(0, 0, 0, 0, 1, 1, 0, 0);
    cycle(); chk("lit_fz_fl", flush_if, 0); adv();
    set_in(0, 0, 0, 0, 0, 1, 0, 0);
    cycle(); adv();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(); chk("lit_fz_exit_st", state_o, 2); chk("lit_fz_exit_fl", flush_if, 0);
    chk("lit_fz_exit_pc", enable_pc, 1); chk("lit_fz_wc", wait_cnt, 3); adv();
    cycle(); chk("lit_fz_pend_fl", flush_if, 1); chk("lit_fz_pend_st", state_o, 0); adv();

    // Reset in the middle of a stall.
    set_in(1, 7, 7, 0, 0, 0, 0, 0);
    cycle(); adv();
    set_in(1, 7, 7, 0, 0, 0, 0, 1);
    cycle(); chk("lit_rst_fl", flush_if, 1); chk("lit_rst_pc", enable_pc, 0);
    chk("lit_rst_sc", stall_cnt, 0); adv();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(); chk("lit_rel_st", state_o, 0); chk("lit_rel_pc", enable_pc, 1);
    chk("lit_rel_fl", flush_if, 0); adv();

    // Saturation, then clear beating an increment.
    set_in(1, 9, 9, 9, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin cycle(); adv(); end
    set_in(1, 9, 9, 9, 0, 0, 1, 0);
    cycle(); chk("lit_sat", stall_cnt, 15); adv();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(); chk("lit_clr", stall_cnt, 0); adv();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if (busy_left == 0 && $urandom_range(0, 11) == 0) busy_left = $urandom_range(1, 4);
      set_in(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), ($urandom_range(0, 7) == 0), (busy_left > 0),
             ($urandom_range(0, 39) == 0), ($urandom_range(0, 149) == 0));
      if (busy_left > 0) busy_left--;
      cycle(); adv();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
